ball_physics: RTL

BALL_PHYSICS -- requirements
Module: ball_physics

---
 rtl/ball_physics.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_physics.sv
// ball_physics: frame-stepped pong ball with SERVE / PLAY / HOLD rounds.
// The ball centre moves once per screenEnd pulse; walls clamp and reflect,
// paddles reflect, and a ball reaching an open goal window ends the round.
// Optional build macro: BALL_SPEEDUP_EN -- each paddle hit raises the
// horizontal step by one pixel (saturating at 6) until the next serve.
module ball_physics #(
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 1,
  parameter int HALF_W       = 10,
  parameter int HALF_H       = 15,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic [9:0] p1_leftBound,
  input  logic [9:0] p1_rightBound,
  input  logic [9:0] p2_leftBound,
  input  logic [9:0] p2_rightBound,
  input  logic [8:0] p1_topBound,
  input  logic [8:0] p1_bottomBound,
  input  logic [8:0] p2_topBound,
  input  logic [8:0] p2_bottomBound,
  input  logic [9:0] ball_xinit,
  input  logic [8:0] ball_yinit,
  input  logic [9:0] ball_xlim,
  input  logic [8:0] ball_ylim,
  input  logic [8:0] segLeft_topBound,
  input  logic [8:0] segLeft_bottomBound,
  input  logic [8:0] segRight_topBound,
  input  logic [8:0] segRight_bottomBound,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [2:0] winner,
  output logic       round_over
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Geometry is compared in 12-bit signed space so that stepping left of
  // column zero or above row zero produces a negative value, never a wrap.
  localparam logic signed [11:0] HW_S   = $signed(12'(HALF_W));
  localparam logic signed [11:0] HH_S   = $signed(12'(HALF_H));
  localparam logic signed [11:0] STEPY_S = $signed(12'(STEP_Y));
  localparam logic [9:0] HW_10       = 10'(HALF_W);
  localparam logic [9:0] LEFT_CLAMP  = 10'(HALF_W + 1);
  localparam logic [8:0] TOP_CLAMP   = 9'(HALF_H + 1);
  localparam logic [3:0] STEP_X_INIT = 4'(STEP_X);
  localparam logic [3:0] STEP_X_MAX  = 4'd6;

  // Zero-extend a 10-bit screen x into the signed comparison space.
  function automatic logic signed [11:0] wide10(input logic [9:0] v);
    wide10 = $signed({2'b00, v});
  endfunction

  // Zero-extend a 9-bit screen y into the signed comparison space.
  function automatic logic signed [11:0] wide9(input logic [8:0] v);
    wide9 = $signed({3'b000, v});
  endfunction

  state_t            state_r, stateNext_s;
  logic [CNT_W-1:0]  cnt_r, cntNext_s;
  logic [9:0]        ballX_r, xNext_s;
  logic [8:0]        ballY_r, yNext_s;
  logic              dx_r, dxNext_s;     // 1 = moving right
  logic              dy_r, dyNext_s;     // 1 = moving down
  logic [2:0]        winner_r, winNext_s;
  logic              roundOver_r, overNext_s;
  logic [3:0]        stepX_s;

  logic signed [11:0] movX_s, movY_s;
  logic signed [11:0] boxL_s, boxR_s, boxT_s, boxB_s;
  logic               hitP1_s, hitP2_s;
  logic               edgeL_s, edgeR_s, goalL_s, goalR_s;
  logic               wallT_s, wallB_s;
  logic [9:0]         p1HitX_s, p2HitX_s, rightClamp_s;
  logic [8:0]         bottomClamp_s;

  // Candidate position one step along the current direction.
  assign movX_s = dx_r ? (wide10(ballX_r) + $signed({8'b0000_0000, stepX_s}))
                       : (wide10(ballX_r) - $signed({8'b0000_0000, stepX_s}));
  assign movY_s = dy_r ? (wide9(ballY_r) + STEPY_S)
                       : (wide9(ballY_r) - STEPY_S);

  // Ball bounding box at the candidate position.
  assign boxL_s = movX_s - HW_S;
  assign boxR_s = movX_s + HW_S;
  assign boxT_s = movY_s - HH_S;
  assign boxB_s = movY_s + HH_S;

  // A paddle only reflects a ball travelling towards it.
  assign hitP1_s = !dx_r &&
                   (boxL_s < wide10(p1_rightBound)) && (boxR_s > wide10(p1_leftBound)) &&
                   (boxT_s < wide9(p1_bottomBound)) && (boxB_s > wide9(p1_topBound));
  assign hitP2_s = dx_r &&
                   (boxL_s < wide10(p2_rightBound)) && (boxR_s > wide10(p2_leftBound)) &&
                   (boxT_s < wide9(p2_bottomBound)) && (boxB_s > wide9(p2_topBound));

  // Side edges; the goal window is judged on the current row, not the next.
  assign edgeL_s = (movX_s <= HW_S);
  assign edgeR_s = (movX_s >= wide10(ball_xlim));
  assign goalL_s = edgeL_s && (ballY_r > segLeft_topBound) && (ballY_r < segLeft_bottomBound);
  assign goalR_s = edgeR_s && (ballY_r > segRight_topBound) && (ballY_r < segRight_bottomBound);

  assign wallT_s = (movY_s <= HH_S);
  assign wallB_s = (movY_s >= wide9(ball_ylim));

  assign p1HitX_s      = p1_rightBound + HW_10;
  assign p2HitX_s      = p2_leftBound - HW_10;
  assign rightClamp_s  = ball_xlim - 10'd1;
  assign bottomClamp_s = ball_ylim - 9'd1;

  // Next-state and next-ball decode for one frame step.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    xNext_s     = ballX_r;
    yNext_s     = ballY_r;
    dxNext_s    = dx_r;
    dyNext_s    = dy_r;
    winNext_s   = winner_r;
    overNext_s  = roundOver_r;
    case (state_r)
      SERVE: begin
        xNext_s = ball_xinit;
        yNext_s = ball_yinit;
        if (cnt_r == CNT_LAST) begin
          cntNext_s   = CNT_ZERO;
          stateNext_s = PLAY;
        end else begin
          cntNext_s = cnt_r + CNT_ONE;
        end
      end
      PLAY: begin
        if (goalL_s) begin
          winNext_s   = 3'd2;
          overNext_s  = 1'b1;
          cntNext_s   = CNT_ZERO;
          stateNext_s = HOLD;
        end else if (goalR_s) begin
          winNext_s   = 3'd1;
          overNext_s  = 1'b1;
          cntNext_s   = CNT_ZERO;
          stateNext_s = HOLD;
        end else begin
          // Horizontal: paddle before side wall.
          if (hitP1_s) begin
            xNext_s  = p1HitX_s;
            dxNext_s = 1'b1;
          end else if (hitP2_s) begin
            xNext_s  = p2HitX_s;
            dxNext_s = 1'b0;
          end else if (edgeL_s) begin
            xNext_s  = LEFT_CLAMP;
            dxNext_s = 1'b1;
          end else if (edgeR_s) begin
            xNext_s  = rightClamp_s;
            dxNext_s = 1'b0;
          end else begin
            xNext_s = movX_s[9:0];
          end
          // Vertical resolves on its own, so corners flip both directions.
          if (wallT_s) begin
            yNext_s  = TOP_CLAMP;
            dyNext_s = 1'b1;
          end else if (wallB_s) begin
            yNext_s  = bottomClamp_s;
            dyNext_s = 1'b0;
          end else begin
            yNext_s = movY_s[8:0];
          end
        end
      end
      HOLD: begin
        if (cnt_r == CNT_LAST) begin
          cntNext_s   = CNT_ZERO;
          overNext_s  = 1'b0;
          stateNext_s = SERVE;
          xNext_s     = ball_xinit;
          yNext_s     = ball_yinit;
          // Serve towards the player who just conceded.
          if (winner_r == 3'd1) begin
            dxNext_s = 1'b1;
          end else begin
            dxNext_s = 1'b0;
          end
        end else begin
          cntNext_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        stateNext_s = SERVE;
        cntNext_s   = CNT_ZERO;
        overNext_s  = 1'b0;
      end
    endcase
  end

  // Frame-gated state, counter and ball registers; reset wins over screenEnd.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      state_r     <= SERVE;
      cnt_r       <= CNT_ZERO;
      ballX_r     <= ball_xinit;
      ballY_r     <= ball_yinit;
      dx_r        <= 1'b1;
      dy_r        <= 1'b1;
      winner_r    <= 3'd0;
      roundOver_r <= 1'b0;
    end else if (screenEnd) begin
      state_r     <= stateNext_s;
      cnt_r       <= cntNext_s;
      ballX_r     <= xNext_s;
      ballY_r     <= yNext_s;
      dx_r        <= dxNext_s;
      dy_r        <= dyNext_s;
      winner_r    <= winNext_s;
      roundOver_r <= overNext_s;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic stepX_r_unused_guard;
  logic [3:0] stepX_r;
  logic       paddleHit_s;
  logic       enterServe_s;

  assign paddleHit_s  = (state_r == PLAY) && !goalL_s && !goalR_s && (hitP1_s || hitP2_s);
  assign enterServe_s = (state_r != SERVE) && (stateNext_s == SERVE);
  assign stepX_r_unused_guard = 1'b0;

  // Horizontal step grows per paddle hit and is restored when a serve begins.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      stepX_r <= STEP_X_INIT;
    end else if (screenEnd) begin
      if (enterServe_s) begin
        stepX_r <= STEP_X_INIT;
      end else if (paddleHit_s && (stepX_r < STEP_X_MAX)) begin
        stepX_r <= stepX_r + 4'd1;
      end
    end
  end

  assign stepX_s = stepX_r | {3'b000, stepX_r_unused_guard};
`else
  assign stepX_s = STEP_X_INIT;
`endif

  assign ball_x     = ballX_r;
  assign ball_y     = ballY_r;
  assign winner     = winner_r;
  assign round_over = roundOver_r;

endmodule
